// File: rtl/ex_mem_stage_pkg.sv
// ex_mem_stage_pkg: shared widths, branch/condition/ALU encodings and the
// NZCV derivation used by the EX->MEM stage.
package ex_mem_stage_pkg;

    localparam int WORD       = 64;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [2:0] {
        BR_NONE  = 3'd0,
        BR_B     = 3'd1,
        BR_CBZ   = 3'd2,
        BR_CBNZ  = 3'd3,
        BR_BCOND = 3'd4
    } br_type_e;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_HS = 4'h2;
    localparam logic [3:0] COND_LO = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    // {N,Z,C,V} from ALU outputs. Carry and overflow only mean something for
    // ADD/SUB; logical ops clear both.
    function automatic logic [3:0] alu_nzcv(input logic       res_msb,
                                            input logic       zero,
                                            input logic       carry,
                                            input logic [3:0] ctrl,
                                            input logic       a_msb,
                                            input logic       b_msb);
        logic c;
        logic v;
        c = 1'b0;
        v = 1'b0;
        if (ctrl == ALU_ADD) begin
            c = carry;
            v = (a_msb == b_msb) && (res_msb != a_msb);
        end else if (ctrl == ALU_SUB) begin
            c = carry;
            v = (a_msb != b_msb) && (res_msb != a_msb);
        end
        return {res_msb, zero, c, v};
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if: EX-side request (valid/ready + ALU/branch/control payload)
// and MEM-side response (registered payload, branch outcome, flags).
// Modports: slave = the pipeline stage, master = the EX/MEM environment.
interface ex_mem_stage_if
    import ex_mem_stage_pkg::*;
#(
    parameter int W      = WORD,
    parameter int REG_AW = REG_AW_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [W-1:0]      alu_result;
    logic              alu_zero;
    logic              alu_carry;
    logic [3:0]        alu_control;
    logic              a_msb;
    logic              b_msb;
    logic              set_flags;
    br_type_e          br_type;
    logic [3:0]        br_cond;
    logic [W-1:0]      br_target;
    logic [W-1:0]      store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;

    logic              out_valid;
    logic              out_ready;
    logic [W-1:0]      q_alu_result;
    logic [W-1:0]      q_store_data;
    logic [REG_AW-1:0] q_rd;
    logic              q_reg_write;
    logic              q_mem_read;
    logic              q_mem_write;
    logic              q_mem_to_reg;
    logic              br_taken;
    logic [W-1:0]      br_target_q;
    logic [3:0]        nzcv;

    modport slave (
        input  in_valid, flush, alu_result, alu_zero, alu_carry, alu_control,
               a_msb, b_msb, set_flags, br_type, br_cond, br_target,
               store_data, rd, reg_write, mem_read, mem_write, mem_to_reg,
               out_ready,
        output in_ready, out_valid, q_alu_result, q_store_data, q_rd,
               q_reg_write, q_mem_read, q_mem_write, q_mem_to_reg,
               br_taken, br_target_q, nzcv
    );

    modport master (
        output in_valid, flush, alu_result, alu_zero, alu_carry, alu_control,
               a_msb, b_msb, set_flags, br_type, br_cond, br_target,
               store_data, rd, reg_write, mem_read, mem_write, mem_to_reg,
               out_ready,
        input  in_ready, out_valid, q_alu_result, q_store_data, q_rd,
               q_reg_write, q_mem_read, q_mem_write, q_mem_to_reg,
               br_taken, br_target_q, nzcv
    );
endinterface

// File: rtl/ex_mem_stage_cond_eval.sv
// cond_eval: combinational ARM condition-code evaluation.
// Ports: nzcv {N,Z,C,V} in, br_cond in, pass out.
module cond_eval (
    input  logic [3:0] nzcv,
    input  logic [3:0] br_cond,
    output logic       pass
);
    logic n, z, c, v;
    logic base;

    assign {n, z, c, v} = nzcv;

    // Conditions come in true/inverted pairs selected by br_cond[0];
    // the 111x pair is "always" in both encodings.
    always_comb begin
        base = 1'b0;
        case (br_cond[3:1])
            3'b000: base = z;
            3'b001: base = c;
            3'b010: base = n;
            3'b011: base = v;
            3'b100: base = c & ~z;
            3'b101: base = (n == v);
            3'b110: base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        pass = (br_cond[3:1] == 3'b111) ? 1'b1 : (base ^ br_cond[0]);
    end
endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register with NZCV flag state and branch
// resolution. Valid/ready on both sides; flush kills the stage contents.
// Ports: clk, rst_n (async, active low), bus (ex_mem_stage_if.slave).
// Build option: COND_BRANCH_EN adds the NZCV register, set_flags and B.cond;
// without it nzcv is 0 and B.cond is never taken.
module ex_mem_stage
    import ex_mem_stage_pkg::*;
#(
    parameter int W      = WORD,
    parameter int REG_AW = REG_AW_DEF
) (
    input logic           clk,
    input logic           rst_n,
    ex_mem_stage_if.slave bus
);
    logic accept;
    logic taken;
    logic taken_r;
    logic cond_pass;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.br_taken = bus.out_valid & taken_r;

`ifdef COND_BRANCH_EN
    logic [3:0] nzcv_r;

    // B.cond reads the register before this accept's own flag update.
    cond_eval u_cond_eval (
        .nzcv    (nzcv_r),
        .br_cond (bus.br_cond),
        .pass    (cond_pass)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nzcv_r <= 4'b0000;
        end else if (accept && bus.set_flags && !bus.flush) begin
            nzcv_r <= alu_nzcv(bus.alu_result[W-1], bus.alu_zero, bus.alu_carry,
                               bus.alu_control, bus.a_msb, bus.b_msb);
        end
    end

    assign bus.nzcv = nzcv_r;
`else
    logic unused_cfg;

    assign unused_cfg = ^{bus.set_flags, bus.br_cond, bus.alu_carry,
                          bus.alu_control, bus.a_msb, bus.b_msb};
    assign cond_pass  = 1'b0;
    assign bus.nzcv   = 4'b0000;
`endif

    always_comb begin
        taken = 1'b0;
        case (bus.br_type)
            BR_B:     taken = 1'b1;
            BR_CBZ:   taken = bus.alu_zero;
            BR_CBNZ:  taken = ~bus.alu_zero;
            BR_BCOND: taken = cond_pass;
            default:  taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid    <= 1'b0;
            taken_r          <= 1'b0;
            bus.q_alu_result <= '0;
            bus.q_store_data <= '0;
            bus.q_rd         <= '0;
            bus.q_reg_write  <= 1'b0;
            bus.q_mem_read   <= 1'b0;
            bus.q_mem_write  <= 1'b0;
            bus.q_mem_to_reg <= 1'b0;
            bus.br_target_q  <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            taken_r       <= 1'b0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            taken_r          <= taken;
            bus.q_alu_result <= bus.alu_result;
            bus.q_store_data <= bus.store_data;
            bus.q_rd         <= bus.rd;
            bus.q_reg_write  <= bus.reg_write;
            bus.q_mem_read   <= bus.mem_read;
            bus.q_mem_write  <= bus.mem_write;
            bus.q_mem_to_reg <= bus.mem_to_reg;
            bus.br_target_q  <= bus.br_target;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            taken_r       <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
    import ex_mem_stage_pkg::*;

`ifdef COND_BRANCH_EN
    localparam logic       CB        = 1'b1;
    localparam logic [3:0] NZCV_SUBS = 4'b0110;
    localparam logic [3:0] NZCV_ADDS = 4'b1001;
`else
    localparam logic       CB        = 1'b0;
    localparam logic [3:0] NZCV_SUBS = 4'b0000;
    localparam logic [3:0] NZCV_ADDS = 4'b0000;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.in_valid    = 1'b0;
        bus.flush       = 1'b0;
        bus.alu_result  = '0;
        bus.alu_zero    = 1'b0;
        bus.alu_carry   = 1'b0;
        bus.alu_control = 4'b0000;
        bus.a_msb       = 1'b0;
        bus.b_msb       = 1'b0;
        bus.set_flags   = 1'b0;
        bus.br_type     = BR_NONE;
        bus.br_cond     = 4'h0;
        bus.br_target   = '0;
        bus.store_data  = '0;
        bus.rd          = '0;
        bus.reg_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.out_ready   = 1'b1;
    endtask

    // ctl = {reg_write, mem_read, mem_write, mem_to_reg}; store_data = ~res
    task automatic set_op(input logic [63:0] res, input logic zero, input logic carry,
                          input logic [3:0] ctrl, input logic am, input logic bm,
                          input logic sf, input br_type_e bt, input logic [3:0] cond,
                          input logic [63:0] tgt, input logic [4:0] rdi,
                          input logic [3:0] ctl);
        bus.in_valid    = 1'b1;
        bus.alu_result  = res;
        bus.alu_zero    = zero;
        bus.alu_carry   = carry;
        bus.alu_control = ctrl;
        bus.a_msb       = am;
        bus.b_msb       = bm;
        bus.set_flags   = sf;
        bus.br_type     = bt;
        bus.br_cond     = cond;
        bus.br_target   = tgt;
        bus.store_data  = ~res;
        bus.rd          = rdi;
        {bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg} = ctl;
    endtask

    task automatic test_reset;
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.nzcv !== 4'b0000) begin failures++; $display("FAIL rst_nzcv got=%b want=0000", bus.nzcv); end
        checks++; if (bus.q_alu_result !== 64'd0) begin failures++; $display("FAIL rst_q_alu got=%h want=0", bus.q_alu_result); end
        step(); step();
        rst_n = 1'b1;
        step();
        // SUBS 5-5 tagged as B so taken and flags are both live before reset
        bus.out_ready = 1'b0;
        set_op(64'd0, 1'b1, 1'b1, ALU_SUB, 1'b0, 1'b0, 1'b1, BR_B, 4'h0, 64'h100, 5'd3, 4'b1000);
        step();
        idle();
        bus.out_ready = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL pre_rst_valid got=%0b want=1", bus.out_valid); end
        checks++; if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL pre_rst_taken got=%0b want=1", bus.br_taken); end
        checks++; if (bus.nzcv !== NZCV_SUBS) begin failures++; $display("FAIL pre_rst_nzcv got=%b want=%b", bus.nzcv, NZCV_SUBS); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL mid_rst_taken got=%0b want=0", bus.br_taken); end
        checks++; if (bus.nzcv !== 4'b0000) begin failures++; $display("FAIL mid_rst_nzcv got=%b want=0000", bus.nzcv); end
        checks++; if (bus.q_rd !== 5'd0) begin failures++; $display("FAIL mid_rst_q_rd got=%0d want=0", bus.q_rd); end
        step();
        rst_n = 1'b1;
        idle();
        step();
    endtask

    task automatic test_subs_beq;
        set_op(64'd0, 1'b1, 1'b1, ALU_SUB, 1'b0, 1'b0, 1'b1, BR_NONE, 4'h0, 64'h0, 5'd1, 4'b1000);
        step();
        checks++; if (bus.nzcv !== NZCV_SUBS) begin failures++; $display("FAIL subs_nzcv got=%b want=%b", bus.nzcv, NZCV_SUBS); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL subs_valid got=%0b want=1", bus.out_valid); end
        checks++; if (bus.q_reg_write !== 1'b1) begin failures++; $display("FAIL subs_reg_write got=%0b want=1", bus.q_reg_write); end
        set_op(64'h1234, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_BCOND, COND_EQ, 64'h400, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== CB) begin failures++; $display("FAIL beq_taken got=%0b want=%0b", bus.br_taken, CB); end
        checks++; if (bus.br_target_q !== 64'h400) begin failures++; $display("FAIL beq_target got=%h want=400", bus.br_target_q); end
        checks++; if (bus.nzcv !== NZCV_SUBS) begin failures++; $display("FAIL beq_nzcv_hold got=%b want=%b", bus.nzcv, NZCV_SUBS); end
        idle();
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL drain_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL drain_taken got=%0b want=0", bus.br_taken); end
    endtask

    task automatic test_adds_overflow;
        set_op(64'h8000_0000_0000_0000, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b1, BR_NONE, 4'h0, 64'h0, 5'd2, 4'b1000);
        step();
        checks++; if (bus.nzcv !== NZCV_ADDS) begin failures++; $display("FAIL adds_nzcv got=%b want=%b", bus.nzcv, NZCV_ADDS); end
        checks++; if (bus.q_alu_result !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL adds_result got=%h want=8000000000000000", bus.q_alu_result); end
        // N=1,V=1: N==V so GE holds and LT does not
        set_op(64'h0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_BCOND, COND_GE, 64'h500, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== CB) begin failures++; $display("FAIL bge_taken got=%0b want=%0b", bus.br_taken, CB); end
        set_op(64'h0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_BCOND, COND_LT, 64'h600, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL blt_taken got=%0b want=0", bus.br_taken); end
        checks++; if (bus.br_target_q !== 64'h600) begin failures++; $display("FAIL blt_target got=%h want=600", bus.br_target_q); end
        idle();
        step();
    endtask

    task automatic test_cbz;
        set_op(64'h0, 1'b1, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, BR_CBZ, 4'h0, 64'h800, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL cbz_z1 got=%0b want=1", bus.br_taken); end
        checks++; if (bus.br_target_q !== 64'h800) begin failures++; $display("FAIL cbz_target got=%h want=800", bus.br_target_q); end
        set_op(64'h0, 1'b1, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, BR_CBNZ, 4'h0, 64'h900, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL cbnz_z1 got=%0b want=0", bus.br_taken); end
        set_op(64'h5, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, BR_CBZ, 4'h0, 64'hA00, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL cbz_z0 got=%0b want=0", bus.br_taken); end
        set_op(64'h5, 1'b0, 1'b0, ALU_SUB, 1'b0, 1'b0, 1'b0, BR_CBNZ, 4'h0, 64'hB00, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL cbnz_z0 got=%0b want=1", bus.br_taken); end
        set_op(64'h5, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_B, 4'h0, 64'hC00, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b1) begin failures++; $display("FAIL b_taken got=%0b want=1", bus.br_taken); end
        set_op(64'h5, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 4'h0, 64'hD00, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL none_taken got=%0b want=0", bus.br_taken); end
        idle();
        step();
    endtask

    task automatic test_stall;
        bus.out_ready = 1'b0;
        set_op(64'hAAAA, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 4'h0, 64'h0, 5'd7, 4'b0010);
        step();
        checks++; if (bus.q_alu_result !== 64'hAAAA) begin failures++; $display("FAIL stall_load got=%h want=aaaa", bus.q_alu_result); end
        set_op(64'hBBBB, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_NONE, 4'h0, 64'h0, 5'd9, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d] got=%0b want=0", i, bus.in_ready); end
            checks++; if (bus.q_alu_result !== 64'hAAAA || bus.q_rd !== 5'd7 || bus.q_mem_write !== 1'b1)
                begin failures++; $display("FAIL stall_hold[%0d] got=%h/%0d/%0b want=aaaa/7/1", i, bus.q_alu_result, bus.q_rd, bus.q_mem_write); end
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%0b want=1", bus.in_ready); end
        step();
        checks++; if (bus.q_alu_result !== 64'hBBBB || bus.q_rd !== 5'd9) begin failures++; $display("FAIL release_load got=%h/%0d want=bbbb/9", bus.q_alu_result, bus.q_rd); end
        checks++; if (bus.q_store_data !== ~64'hBBBB) begin failures++; $display("FAIL release_store got=%h want=%h", bus.q_store_data, ~64'hBBBB); end
        checks++; if ({bus.q_reg_write, bus.q_mem_read, bus.q_mem_write, bus.q_mem_to_reg} !== 4'b0101)
            begin failures++; $display("FAIL release_ctl got=%b want=0101", {bus.q_reg_write, bus.q_mem_read, bus.q_mem_write, bus.q_mem_to_reg}); end
        idle();
        step();
    endtask

    task automatic test_flush;
        set_op(64'd0, 1'b1, 1'b1, ALU_SUB, 1'b0, 1'b0, 1'b1, BR_B, 4'h0, 64'hE00, 5'd4, 4'b1000);
        bus.flush = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%0b want=0", bus.out_valid); end
        checks++; if (bus.br_taken !== 1'b0) begin failures++; $display("FAIL flush_taken got=%0b want=0", bus.br_taken); end
        checks++; if (bus.nzcv !== NZCV_ADDS) begin failures++; $display("FAIL flush_nzcv got=%b want=%b", bus.nzcv, NZCV_ADDS); end
        idle();
        step();
    endtask

    task automatic test_bal;
        set_op(64'h0, 1'b0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0, BR_BCOND, COND_AL, 64'hF00, 5'd0, 4'b0000);
        step();
        checks++; if (bus.br_taken !== CB) begin failures++; $display("FAIL bal_taken got=%0b want=%0b", bus.br_taken, CB); end
        checks++; if (bus.nzcv !== NZCV_ADDS) begin failures++; $display("FAIL bal_nzcv got=%b want=%b", bus.nzcv, NZCV_ADDS); end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_subs_beq();
        test_adds_overflow();
        test_cbz();
        test_stall();
        test_flush();
        test_bal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
